// File: rtl/neighbor_table_writer.sv
// neighbor_table_writer
//   Processes one neighbor announcement at a time against a word-wide
//   memory holding the neighbor table and the known-sink table.
//   An announcement updates the cluster ID of a known neighbor or
//   appends a new one, and registers the announcer as a sink when
//   flagged and not already known.
//
//   Memory map (byte addresses, 16-bit words):
//     0x0688          knownSinkCount
//     0x068A          neighborCount
//     0x0048 + 2*i    neighborID[i]   (i < 64)
//     0x00C8 + 2*i    clusterID[i]    (i < 64)
//     0x0008 + 2*j    knownSinks[j]   (j < 32)
//
// Ports
//   clock         rising-edge clock
//   nrst          synchronous active-low reset
//   in_valid      announcement present
//   in_ready      block idle and able to accept
//   in_node_id    announcing neighbor ID
//   in_cluster_id announcing neighbor's cluster ID
//   in_is_sink    announcing neighbor is a sink
//   address       memory byte address (registered)
//   wr_en         memory write strobe (registered)
//   data_out      memory write data (registered)
//   data_in       memory read data, valid the cycle after address
//   done          one-cycle pulse at the end of an announcement
//   table_full    last announcement dropped, neighbor table full
//   sink_full     last sink registration dropped, sink table full

module neighbor_table_writer (
    input  logic        clock,
    input  logic        nrst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_node_id,
    input  logic [15:0] in_cluster_id,
    input  logic        in_is_sink,
    output logic [15:0] address,
    output logic        wr_en,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    output logic        done,
    output logic        table_full,
    output logic        sink_full
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_NCNT  = 4'd1,
        RD_SCNT  = 4'd2,
        LAT_SCNT = 4'd3,
        N_ADDR   = 4'd4,
        N_CMP    = 4'd5,
        N_WR_ID  = 4'd6,
        N_WR_CID = 4'd7,
        N_WR_CNT = 4'd8,
        S_ADDR   = 4'd9,
        S_CMP    = 4'd10,
        S_WR_ID  = 4'd11,
        S_WR_CNT = 4'd12,
        DONE     = 4'd13
    } state_t;

    localparam logic [15:0] ADDR_SCNT = 16'h0688;
    localparam logic [15:0] ADDR_NCNT = 16'h068A;
    localparam logic [15:0] BASE_NID  = 16'h0048;
    localparam logic [15:0] BASE_CID  = 16'h00C8;
    localparam logic [15:0] BASE_SINK = 16'h0008;
    localparam logic [15:0] NBR_MAX   = 16'd64;
    localparam logic [15:0] SINK_MAX  = 16'd32;

    // Word slot address: base + 2*idx, 16-bit wrap-around arithmetic.
    function automatic logic [15:0] slot(input logic [15:0] base, input logic [15:0] idx);
        return base + {idx[14:0], 1'b0};
    endfunction

    state_t      state_q,    state_d;
    logic [15:0] id_q,       id_d;
    logic [15:0] cid_q,      cid_d;
    logic        sink_q,     sink_d;
    logic [15:0] ncnt_q,     ncnt_d;
    logic [15:0] scnt_q,     scnt_d;
    logic [15:0] i_q,        i_d;
    logic [15:0] j_q,        j_d;
    logic        app_q,      app_d;
    logic [15:0] address_q,  address_d;
    logic [15:0] data_out_q, data_out_d;
    logic        wr_en_q,    wr_en_d;
    logic        done_q,     done_d;
    logic        tfull_q,    tfull_d;
    logic        sfull_q,    sfull_d;

    // Outputs are registered and take the value belonging to the state
    // being entered, so a read address is visible during the state that
    // issues it and its data arrives in the following state.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        cid_d      = cid_q;
        sink_d     = sink_q;
        ncnt_d     = ncnt_q;
        scnt_d     = scnt_q;
        i_d        = i_q;
        j_d        = j_q;
        app_d      = app_q;
        address_d  = address_q;
        data_out_d = data_out_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        tfull_d    = tfull_q;
        sfull_d    = sfull_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    id_d      = in_node_id;
                    cid_d     = in_cluster_id;
                    sink_d    = in_is_sink;
                    tfull_d   = 1'b0;
                    sfull_d   = 1'b0;
                    app_d     = 1'b0;
                    address_d = ADDR_NCNT;
                    state_d   = RD_NCNT;
                end
            end

            RD_NCNT: begin
                address_d = ADDR_SCNT;
                state_d   = RD_SCNT;
            end

            RD_SCNT: begin
                ncnt_d  = (data_in > NBR_MAX) ? NBR_MAX : data_in;
                state_d = LAT_SCNT;
            end

            LAT_SCNT: begin
                scnt_d    = (data_in > SINK_MAX) ? SINK_MAX : data_in;
                i_d       = '0;
                address_d = BASE_NID;
                state_d   = N_ADDR;
            end

            N_ADDR: begin
                if (i_q == ncnt_q) begin
                    if (ncnt_q < NBR_MAX) begin
                        wr_en_d    = 1'b1;
                        address_d  = slot(BASE_NID, ncnt_q);
                        data_out_d = id_q;
                        state_d    = N_WR_ID;
                    end else begin
                        tfull_d   = 1'b1;
                        j_d       = '0;
                        address_d = BASE_SINK;
                        state_d   = S_ADDR;
                    end
                end else begin
                    state_d = N_CMP;
                end
            end

            N_CMP: begin
                if (data_in == id_q) begin
                    // Existing neighbor: refresh cluster ID in place.
                    app_d      = 1'b0;
                    wr_en_d    = 1'b1;
                    address_d  = slot(BASE_CID, i_q);
                    data_out_d = cid_q;
                    state_d    = N_WR_CID;
                end else begin
                    i_d       = i_q + 16'd1;
                    address_d = slot(BASE_NID, i_q + 16'd1);
                    state_d   = N_ADDR;
                end
            end

            N_WR_ID: begin
                app_d      = 1'b1;
                wr_en_d    = 1'b1;
                address_d  = slot(BASE_CID, ncnt_q);
                data_out_d = cid_q;
                state_d    = N_WR_CID;
            end

            N_WR_CID: begin
                if (app_q) begin
                    wr_en_d    = 1'b1;
                    address_d  = ADDR_NCNT;
                    data_out_d = ncnt_q + 16'd1;
                    state_d    = N_WR_CNT;
                end else begin
                    j_d       = '0;
                    address_d = BASE_SINK;
                    state_d   = S_ADDR;
                end
            end

            N_WR_CNT: begin
                j_d       = '0;
                address_d = BASE_SINK;
                state_d   = S_ADDR;
            end

            S_ADDR: begin
                if (!sink_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (j_q == scnt_q) begin
                    if (scnt_q < SINK_MAX) begin
                        wr_en_d    = 1'b1;
                        address_d  = slot(BASE_SINK, scnt_q);
                        data_out_d = id_q;
                        state_d    = S_WR_ID;
                    end else begin
                        sfull_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = S_CMP;
                end
            end

            S_CMP: begin
                if (data_in == id_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    j_d       = j_q + 16'd1;
                    address_d = slot(BASE_SINK, j_q + 16'd1);
                    state_d   = S_ADDR;
                end
            end

            S_WR_ID: begin
                wr_en_d    = 1'b1;
                address_d  = ADDR_SCNT;
                data_out_d = scnt_q + 16'd1;
                state_d    = S_WR_CNT;
            end

            S_WR_CNT: begin
                done_d  = 1'b1;
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_q    <= IDLE;
            id_q       <= '0;
            cid_q      <= '0;
            sink_q     <= 1'b0;
            ncnt_q     <= '0;
            scnt_q     <= '0;
            i_q        <= '0;
            j_q        <= '0;
            app_q      <= 1'b0;
            address_q  <= '0;
            data_out_q <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            tfull_q    <= 1'b0;
            sfull_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            cid_q      <= cid_d;
            sink_q     <= sink_d;
            ncnt_q     <= ncnt_d;
            scnt_q     <= scnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            app_q      <= app_d;
            address_q  <= address_d;
            data_out_q <= data_out_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            tfull_q    <= tfull_d;
            sfull_q    <= sfull_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign address    = address_q;
    assign wr_en      = wr_en_q;
    assign data_out   = data_out_q;
    assign done       = done_q;
    assign table_full = tfull_q;
    assign sink_full  = sfull_q;

endmodule

// File: tb/tb_neighbor_table_writer.sv
// Directed bench for neighbor_table_writer with a word-wide memory model
// (one-cycle registered read) and a log of every write strobe.

module tb_neighbor_table_writer;

    logic        clock = 1'b0;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_node_id;
    logic [15:0] in_cluster_id;
    logic        in_is_sink;
    logic [15:0] address;
    logic        wr_en;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        done;
    logic        table_full;
    logic        sink_full;

    neighbor_table_writer dut (
        .clock        (clock),
        .nrst         (nrst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_node_id   (in_node_id),
        .in_cluster_id(in_cluster_id),
        .in_is_sink   (in_is_sink),
        .address      (address),
        .wr_en        (wr_en),
        .data_out     (data_out),
        .data_in      (data_in),
        .done         (done),
        .table_full   (table_full),
        .sink_full    (sink_full)
    );

    always #5 clock = ~clock;

    // Memory model, write log and handshake counters.
    logic [15:0] mem [0:1023];
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [15:0] pl_data;
    logic [15:0] wa [0:255];
    logic [15:0] wd [0:255];
    int unsigned wn    = 0;
    int unsigned nacc  = 0;
    int unsigned ndone = 0;

    always @(posedge clock) begin
        data_in <= mem[address[10:1]];
        if (pl_en) mem[pl_addr[10:1]] <= pl_data;
        else if (wr_en) mem[address[10:1]] <= data_out;
        if (wr_en) begin
            if (wn < 256) begin
                wa[wn] <= address;
                wd[wn] <= data_out;
            end
            wn <= wn + 1;
        end
        if (in_valid && in_ready) nacc <= nacc + 1;
        if (done) ndone <= ndone + 1;
    end

    int total = 0;
    int bad   = 0;
    int unsigned base_g = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int k, input logic [15:0] a, input logic [15:0] d);
        check({tag, "_addr"}, {16'h0, wa[base_g + k]}, {16'h0, a});
        check({tag, "_data"}, {16'h0, wd[base_g + k]}, {16'h0, d});
    endtask

    function automatic logic [15:0] m(input logic [15:0] a);
        return mem[a[10:1]];
    endfunction

    task automatic pl(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clock);
        #1 pl_en = 1'b0;
    endtask

    task automatic push(input logic [15:0] id, input logic [15:0] cid, input logic sink,
                        output int cyc, output logic tf_acc, output logic sf_acc);
        @(negedge clock);
        base_g        = wn;
        in_valid      = 1'b1;
        in_node_id    = id;
        in_cluster_id = cid;
        in_is_sink    = sink;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        cyc      = 1;
        tf_acc   = table_full;
        sf_acc   = sink_full;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    int          cyc;
    logic        tfa, sfa;
    int unsigned acc0, d0;

    initial begin
        nrst = 1'b0; in_valid = 1'b0; in_node_id = '0; in_cluster_id = '0;
        in_is_sink = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clock);
        check("rst_ready", {31'h0, in_ready}, 32'h1);
        check("rst_addr", {16'h0, address}, 32'h0);
        check("rst_data", {16'h0, data_out}, 32'h0);
        check("rst_wr", {31'h0, wr_en}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_tfull", {31'h0, table_full}, 32'h0);
        check("rst_sfull", {31'h0, sink_full}, 32'h0);
        nrst = 1'b1;

        // Empty tables, plain neighbor append.
        pl(16'h068A, 16'h0000);
        pl(16'h0688, 16'h0000);
        push(16'h0005, 16'h0002, 1'b0, cyc, tfa, sfa);
        check("t1_cycles", cyc, 9);
        check("t1_done", {31'h0, done}, 32'h1);
        check("t1_nwr", wn - base_g, 3);
        chk_wr("t1_w0", 0, 16'h0048, 16'h0005);
        chk_wr("t1_w1", 1, 16'h00C8, 16'h0002);
        chk_wr("t1_w2", 2, 16'h068A, 16'h0001);
        @(negedge clock);
        check("t1_done_pulse", {31'h0, done}, 32'h0);
        check("t1_ready_after", {31'h0, in_ready}, 32'h1);

        // Known neighbor at index 1: cluster refresh only.
        pl(16'h068A, 16'h0002);
        pl(16'h0688, 16'h0000);
        pl(16'h0048, 16'h0003);
        pl(16'h004A, 16'h0005);
        push(16'h0005, 16'h0007, 1'b0, cyc, tfa, sfa);
        check("t2_cycles", cyc, 10);
        check("t2_nwr", wn - base_g, 1);
        chk_wr("t2_w0", 0, 16'h00CA, 16'h0007);

        // Neighbor append plus new sink after one known sink.
        pl(16'h068A, 16'h0000);
        pl(16'h0688, 16'h0001);
        pl(16'h0008, 16'h0009);
        push(16'h0004, 16'h0001, 1'b1, cyc, tfa, sfa);
        check("t3_cycles", cyc, 13);
        check("t3_nwr", wn - base_g, 5);
        chk_wr("t3_w0", 0, 16'h0048, 16'h0004);
        chk_wr("t3_w1", 1, 16'h00C8, 16'h0001);
        chk_wr("t3_w2", 2, 16'h068A, 16'h0001);
        chk_wr("t3_w3", 3, 16'h000A, 16'h0004);
        chk_wr("t3_w4", 4, 16'h0688, 16'h0002);
        check("t3_sfull", {31'h0, sink_full}, 32'h0);

        // Same node again: neighbor refresh, sink found at j=1.
        push(16'h0004, 16'h0006, 1'b1, cyc, tfa, sfa);
        check("t4_cycles", cyc, 11);
        check("t4_nwr", wn - base_g, 1);
        chk_wr("t4_w0", 0, 16'h00C8, 16'h0006);

        // Full neighbor table, no match.
        pl(16'h068A, 16'd64);
        pl(16'h0688, 16'h0000);
        for (int i = 0; i < 64; i++) pl(16'h0048 + 16'(2 * i), 16'h1000 + 16'(i));
        push(16'h00AA, 16'h0011, 1'b0, cyc, tfa, sfa);
        check("t5_cycles", cyc, 134);
        check("t5_nwr", wn - base_g, 0);
        check("t5_tfull", {31'h0, table_full}, 32'h1);
        check("t5_sfull", {31'h0, sink_full}, 32'h0);
        repeat (3) @(negedge clock);
        check("t5_tfull_hold", {31'h0, table_full}, 32'h1);

        // Oversized counts saturate; match at i=5, sink table full.
        pl(16'h068A, 16'h0100);
        pl(16'h0688, 16'h0050);
        for (int j = 0; j < 32; j++) pl(16'h0008 + 16'(2 * j), 16'h2000 + 16'(j));
        push(16'h1005, 16'h0033, 1'b1, cyc, tfa, sfa);
        check("t6_tfull_clr", {31'h0, tfa}, 32'h0);
        check("t6_cycles", cyc, 82);
        check("t6_nwr", wn - base_g, 1);
        chk_wr("t6_w0", 0, 16'h00D2, 16'h0033);
        check("t6_sfull", {31'h0, sink_full}, 32'h1);
        check("t6_tfull", {31'h0, table_full}, 32'h0);
        check("t6_cnt_kept", {16'h0, m(16'h068A)}, 32'h0100);

        // Reset during neighbor scan aborts without writes.
        @(negedge clock);
        base_g = wn; d0 = ndone;
        in_valid = 1'b1; in_node_id = 16'hBEEF; in_cluster_id = 16'h0044; in_is_sink = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        check("t7_sfull_clr", {31'h0, sink_full}, 32'h0);
        repeat (10) @(negedge clock);
        nrst = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("t7_ready", {31'h0, in_ready}, 32'h1);
        check("t7_addr", {16'h0, address}, 32'h0);
        check("t7_data", {16'h0, data_out}, 32'h0);
        check("t7_wr", {31'h0, wr_en}, 32'h0);
        check("t7_done", {31'h0, done}, 32'h0);
        check("t7_tfull", {31'h0, table_full}, 32'h0);
        nrst = 1'b1;
        repeat (6) @(negedge clock);
        check("t7_nwr", wn - base_g, 0);
        check("t7_ndone", ndone - d0, 0);
        check("t7_idle", {31'h0, in_ready}, 32'h1);

        // in_valid held high with changing data for 20 cycles.
        pl(16'h068A, 16'h0000);
        pl(16'h0688, 16'h0000);
        @(negedge clock);
        base_g = wn; acc0 = nacc; d0 = ndone;
        for (int k = 0; k < 20; k++) begin
            in_valid      = 1'b1;
            in_node_id    = 16'h0100 + 16'(k);
            in_cluster_id = 16'h0200 + 16'(k);
            in_is_sink    = 1'b0;
            @(negedge clock);
        end
        in_valid = 1'b0;
        for (int t = 0; t < 100 && (ndone - d0) < 2; t++) @(negedge clock);
        repeat (2) @(negedge clock);
        check("t8_accepts", nacc - acc0, 2);
        check("t8_dones", ndone - d0, 2);
        check("t8_nwr", wn - base_g, 6);
        chk_wr("t8_w0", 0, 16'h0048, 16'h0100);
        chk_wr("t8_w1", 1, 16'h00C8, 16'h0200);
        chk_wr("t8_w2", 2, 16'h068A, 16'h0001);
        chk_wr("t8_w3", 3, 16'h004A, 16'h010A);
        chk_wr("t8_w4", 4, 16'h00CA, 16'h020A);
        chk_wr("t8_w5", 5, 16'h068A, 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neighbor_table_writer.md
NEIGHBOR_TABLE_WRITER -- requirements
Module: neighbor_table_writer

Interface
REQ-001 SHALL have port: clock  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: nrst  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: in_valid  input  1  neighbor announcement present.
REQ-004 SHALL have port: in_ready  output  1  block can accept an announcement.
REQ-005 SHALL have port: in_node_id  input  16  announcing neighbor ID.
REQ-006 SHALL have port: in_cluster_id  input  16  neighbor's cluster ID.
REQ-007 SHALL have port: in_is_sink  input  1  neighbor is a sink.
REQ-008 SHALL have port: address  output  16  memory byte address.
REQ-009 SHALL have port: wr_en  output  1  memory write strobe.
REQ-010 SHALL have port: data_out  output  16  memory write data.
REQ-011 SHALL have port: data_in  input  16  memory read data, valid one cycle after address is presented.
REQ-012 SHALL have port: done  output  1  one-cycle pulse when an announcement is fully processed.
REQ-013 SHALL have port: table_full  output  1  last announcement dropped, neighbor table full.
REQ-014 SHALL have port: sink_full  output  1  last sink registration dropped, sink table full.

Function
REQ-015 SHALL use memory map: knownSinkCount 0x688, neighborCount 0x68A, neighborID[i] 0x48+2i (i<64), clusterID[i] 0xC8+2i, knownSinks[j] 0x08+2j (j<32).
REQ-016 SHALL use states IDLE, RD_NCNT, RD_SCNT, LAT_SCNT, N_ADDR, N_CMP, N_WR_ID, N_WR_CID, N_WR_CNT, S_ADDR, S_CMP, S_WR_ID, S_WR_CNT, DONE.
REQ-017 SHALL drive in_ready=1 exactly when state is IDLE.
REQ-018 SHALL accept when in_valid && in_ready at a clock edge: latch id/cluster/is_sink, clear table_full and sink_full, go RD_NCNT.
REQ-019 SHALL ignore in_valid and input data in every state other than IDLE.
REQ-020 RD_NCNT: address=0x68A -> RD_SCNT; RD_SCNT: latch ncnt=data_in, address=0x688 -> LAT_SCNT; LAT_SCNT: latch scnt=data_in, i=0 -> N_ADDR.
REQ-021 SHALL saturate latched ncnt to 64 and scnt to 32 when memory holds larger values.
REQ-022 N_ADDR: if i==ncnt -> N_WR_ID when ncnt<64, else set table_full and skip to S_ADDR (j=0); otherwise address=0x48+2i -> N_CMP.
REQ-023 N_CMP: if data_in==latched id -> N_WR_CID with update index=i; else i=i+1 -> N_ADDR (two cycles per scanned entry).
REQ-024 N_WR_ID: one-cycle write address=0x48+2*ncnt, data_out=id -> N_WR_CID with update index=ncnt, append flag set.
REQ-025 N_WR_CID: one-cycle write address=0xC8+2*index, data_out=cluster -> N_WR_CNT if append flag, else S_ADDR (j=0).
REQ-026 N_WR_CNT: one-cycle write address=0x68A, data_out=ncnt+1 -> S_ADDR (j=0).
REQ-027 S_ADDR: if latched is_sink==0 -> DONE; if j==scnt -> S_WR_ID when scnt<32, else set sink_full -> DONE; otherwise address=0x08+2j -> S_CMP.
REQ-028 S_CMP: data_in==id -> DONE (already known); else j=j+1 -> S_ADDR.
REQ-029 S_WR_ID: one-cycle write address=0x08+2*scnt, data_out=id -> S_WR_CNT; S_WR_CNT: write address=0x688, data_out=scnt+1 -> DONE.
REQ-030 wr_en SHALL be 1 only in N_WR_ID, N_WR_CID, N_WR_CNT, S_WR_ID, S_WR_CNT, and for exactly one cycle each.
REQ-031 DONE: done=1 for one cycle -> IDLE; table_full/sink_full SHALL hold until next accept.
REQ-032 All index/address arithmetic SHALL be 16-bit unsigned; count+1 never exceeds 64/32 due to REQ-022/REQ-027.
REQ-033 Undefined state encodings SHALL return to IDLE on next clock with wr_en=0.

Reset
REQ-034 nrst low at a clock edge SHALL force state=IDLE, address=0x0000, data_out=0x0000, wr_en=0, done=0, table_full=0, sink_full=0, counters/indices=0, regardless of current state.
REQ-035 Reset mid-operation SHALL abort with no further writes; in_ready=1 from the cycle after reset.

Verification
REQ-036 Empty memory (ncnt=0, scnt=0), push id=0x0005 cid=0x0002 sink=0 -> writes 0x48<=0x0005, 0xC8<=0x0002, 0x68A<=0x0001, no 0x688 write, done pulse, 9 cycles accept-to-done.
REQ-037 ncnt=2, [0x48]=0x0003, [0x4A]=0x0005, push id=0x0005 cid=0x0007 -> single write 0xCA<=0x0007, no count write.
REQ-038 ncnt=0, scnt=1, [0x08]=0x0009, push id=0x0004 cid=0x0001 sink=1 -> neighbor append plus 0x0A<=0x0004, 0x688<=0x0002.
REQ-039 ncnt=64 with no match, sink=0 -> zero writes, table_full=1 after done, cleared on next accept.
REQ-040 nrst low during N_CMP scan -> wr_en stays 0, outputs at reset values, in_ready=1 next cycle.
REQ-041 in_valid held high for 20 cycles with changing data -> exactly one accept per IDLE visit, latched values unchanged mid-operation.
